mem_bridge: RTL and testbench
=============================

MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 SHALL have parameter ABITS, default 10, meaning the word-address width of the attached RAM (1024 words).
REQ-002 SHALL have parameter WAIT, default 2, meaning the number of RAM read-latency cycles (legal range 1..7).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port clr, input, 1, the reset: synchronous, active-high.
REQ-005 SHALL have port cpu_req, input, 1, the CPU access request.
REQ-006 SHALL have port cpu_we, input, 1, which selects a write (1) or a read (0).
REQ-007 SHALL have port cpu_adr, input, 32, the CPU byte address.
REQ-008 SHALL have port cpu_wdata, input, 32, the write data.
REQ-009 SHALL have port cpu_rdata, output, 32, the registered read data.
REQ-010 SHALL have port cpu_ready, output, 1, a one-cycle completion pulse.
REQ-011 SHALL have port cpu_err, output, 1, a misalignment error flag, valid with cpu_ready.
REQ-012 SHALL have port mem_en, output, 1, the RAM enable.
REQ-013 SHALL have port mem_we, output, 1, the RAM write enable.
REQ-014 SHALL have port mem_adr, output, ABITS, the RAM word address, equal to cpu_adr[ABITS+1:2].
REQ-015 SHALL have port mem_wdata, output, 32, the RAM write data.
REQ-016 SHALL have port mem_rdata, input, 32, the RAM read data, valid WAIT cycles after the mem_en read cycle.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAITRD, DONE.
REQ-018 SHALL, in IDLE with cpu_req=1, latch cpu_we, cpu_adr and cpu_wdata and go to ISSUE; the CPU need not hold its inputs after this accept cycle.
REQ-019 SHALL, in IDLE with cpu_req=0, stay in IDLE with mem_en=0.
REQ-020 SHALL, in ISSUE with an aligned latched address (adr[1:0]=0), drive mem_en=1 for exactly one cycle, with mem_we equal to the latched we.
REQ-021 SHALL, from ISSUE, go to DONE for a write and to WAITRD for a read.
REQ-022 SHALL, in WAITRD, count WAIT-1 further cycles using a 3-bit down-counter, then capture mem_rdata into cpu_rdata and go to DONE.
REQ-023 SHALL, in DONE, assert cpu_ready=1 for one cycle and return to IDLE.
REQ-024 SHALL give the following latency, from the accept edge to the cpu_ready pulse: write = 2 cycles; read = WAIT+2 cycles.
REQ-025 SHALL, for a misaligned address, issue no RAM access (mem_en stays 0), go ISSUE->DONE, and assert cpu_err=1 with cpu_ready.
REQ-026 SHALL leave cpu_rdata unchanged on a misaligned read.
REQ-027 SHALL hold cpu_rdata between accesses, updating it only on a successful read.
REQ-028 SHALL ignore cpu_req outside IDLE; a request held high through DONE is accepted on the next IDLE cycle, giving a 1-cycle bubble between back-to-back accesses.
REQ-029 SHALL ignore cpu_adr bits above ABITS+1, so the address wraps modulo 2^ABITS words.
REQ-030 SHALL drive cpu_err=0 whenever cpu_ready=0.

Reset
REQ-031 SHALL, while clr=1 at a clock edge, force state=IDLE, cpu_ready=0, cpu_err=0, cpu_rdata=0, mem_en=0, mem_we=0, counter=0, and clear the latched address and data to 0.
REQ-032 SHALL, when reset is asserted mid-access, abort the access with no cpu_ready; a write whose ISSUE cycle has already passed remains committed in the RAM.
REQ-033 SHALL, when clr and cpu_req are both high, not accept the request.

Structure
REQ-034 SHALL declare the state enum (IDLE, ISSUE, WAITRD, DONE) and the constant ADDR_ALIGN_MASK=2'b11 in the shared package mc_pkg.
REQ-035 SHALL need no sub-module; the wait counter is inline, and an optional sync-RAM behavioural model sync_ram, with WAIT-cycle latency, is for the bench only.

Verification
REQ-036 SHALL cover the single-write scenario: write 0xDEADBEEF to 0x0000_0010 -> mem_en=1, mem_we=1, mem_adr=4 in ISSUE, and cpu_ready 2 cycles after accept with cpu_err=0.
REQ-037 SHALL cover the read-back scenario: read 0x0000_0010 with WAIT=2 -> cpu_ready 4 cycles after accept with cpu_rdata=0xDEADBEEF.
REQ-038 SHALL cover the misaligned-read scenario: read 0x0000_0013 -> mem_en never asserted, cpu_ready+cpu_err at cycle 2, cpu_rdata unchanged.
REQ-039 SHALL cover the back-to-back scenario: cpu_req held high for write A then read A -> second accept exactly 1 cycle after the first cpu_ready, and read returns the data of write A.
REQ-040 SHALL cover the reset-mid-read scenario: clr=1 during WAITRD -> next cycle IDLE, all outputs 0, no cpu_ready pulse.
REQ-041 SHALL cover the wrap scenario: write 0x1111_1111 to 0x0000_1000 (ABITS=10) -> mem_adr=0, and a read of 0x0 returns 0x1111_1111.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the CPU-to-sync-RAM bridge.
package mc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAITRD,
        DONE
    } state_t;

    localparam logic [1:0] ADDR_ALIGN_MASK = 2'b11;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb & ADDR_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_bridge_if.sv
// CPU-side and RAM-side bus bundles of the memory bridge.
interface mb_cpu_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_adr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;

    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_err
    );
    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_err
    );
endinterface

interface mb_mem_if #(
    parameter int ABITS = 10
);
    logic             mem_en;
    logic             mem_we;
    logic [ABITS-1:0] mem_adr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;

    modport master (
        output mem_en, mem_we, mem_adr, mem_wdata,
        input  mem_rdata
    );
    modport slave (
        input  mem_en, mem_we, mem_adr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_bridge.sv
// Single-outstanding CPU to synchronous-RAM bridge with a fixed
// read latency and misaligned-access error reporting.
module mem_bridge
    import mc_pkg::*;
#(
    parameter int ABITS = 10,
    parameter int WAIT  = 2
) (
    input  logic    clk,
    input  logic    clr,
    mb_cpu_if.slave cpu,
    mb_mem_if.master mem
);

    localparam logic [2:0] CNT_INIT = 3'(WAIT - 1);

    state_t           state_q;
    logic             we_q;
    logic [ABITS+1:0] adr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             ready_q;
    logic             err_q;
    logic             en_q;
    logic             mwe_q;
    logic [2:0]       cnt_q;

    logic             aligned_d;
    logic             unused_adr;

    assign aligned_d  = is_aligned(cpu.cpu_adr[1:0]);
    assign unused_adr = ^cpu.cpu_adr[31:ABITS+2];

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            mwe_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            mwe_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cpu.cpu_req) begin
                        we_q    <= cpu.cpu_we;
                        adr_q   <= cpu.cpu_adr[ABITS+1:0];
                        wdata_q <= cpu.cpu_wdata;
                        // RAM strobes are registered so they line up with ISSUE
                        en_q    <= aligned_d;
                        mwe_q   <= aligned_d & cpu.cpu_we;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!is_aligned(adr_q[1:0])) begin
                        ready_q <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else if (we_q) begin
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= CNT_INIT;
                        state_q <= WAITRD;
                    end
                end
                WAITRD: begin
                    if (cnt_q == 3'd0) begin
                        rdata_q <= mem.mem_rdata;
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu.cpu_rdata = rdata_q;
    assign cpu.cpu_ready = ready_q;
    assign cpu.cpu_err   = err_q;

    assign mem.mem_en    = en_q;
    assign mem.mem_we    = mwe_q;
    assign mem.mem_adr   = adr_q[ABITS+1:2];
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge with a WAIT-cycle sync RAM model.
module tb_mem_bridge;

    logic clk;
    logic clr;
    int   checks;
    int   errors;

    mb_cpu_if cpu_if ();
    mb_mem_if #(.ABITS(10)) mem_if ();

    mem_bridge #(
        .ABITS(10),
        .WAIT (2)
    ) dut (
        .clk(clk),
        .clr(clr),
        .cpu(cpu_if.slave),
        .mem(mem_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram [1024];
    logic [31:0] p0;
    logic [31:0] p1;

    always @(posedge clk) begin
        if (mem_if.mem_en) begin
            if (mem_if.mem_we) ram[mem_if.mem_adr] <= mem_if.mem_wdata;
            else p0 <= ram[mem_if.mem_adr];
        end
        p1 <= p0;
    end
    assign mem_if.mem_rdata = p1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int          lat;
    int          en_cyc;
    int          en_n;
    int          err_bad;
    logic        err;
    logic        iss_we;
    logic [9:0]  iss_adr;
    logic [31:0] iss_wd;

    // Called at a negedge; drives the request now and drops it at drop_cyc.
    task automatic acc(input logic we, input logic [31:0] adr,
                       input logic [31:0] wd, input int drop_cyc);
        cpu_if.cpu_req   = 1'b1;
        cpu_if.cpu_we    = we;
        cpu_if.cpu_adr   = adr;
        cpu_if.cpu_wdata = wd;
        lat = -1; en_cyc = -1; en_n = 0; err_bad = 0;
        err = 1'bx; iss_we = 1'bx; iss_adr = 'x; iss_wd = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == drop_cyc) cpu_if.cpu_req = 1'b0;
            if (mem_if.mem_en) begin
                en_n++;
                if (en_cyc < 0) begin
                    en_cyc  = c;
                    iss_we  = mem_if.mem_we;
                    iss_adr = mem_if.mem_adr;
                    iss_wd  = mem_if.mem_wdata;
                end
            end
            if (cpu_if.cpu_err && !cpu_if.cpu_ready) err_bad++;
            if (cpu_if.cpu_ready) begin
                lat = c;
                err = cpu_if.cpu_err;
                break;
            end
        end
    endtask

    int rdy_seen;

    initial begin
        checks = 0;
        errors = 0;
        clr = 1'b1;
        cpu_if.cpu_req   = 1'b0;
        cpu_if.cpu_we    = 1'b0;
        cpu_if.cpu_adr   = '0;
        cpu_if.cpu_wdata = '0;
        repeat (3) @(negedge clk);
        cpu_if.cpu_req = 1'b1;
        @(negedge clk);
        cpu_if.cpu_req = 1'b0;
        clr = 1'b0;
        chk("rst_ready", 32'(cpu_if.cpu_ready), 0);
        chk("rst_err", 32'(cpu_if.cpu_err), 0);
        chk("rst_rdata", cpu_if.cpu_rdata, 0);
        chk("rst_en", 32'(mem_if.mem_en), 0);
        chk("rst_we", 32'(mem_if.mem_we), 0);
        chk("rst_adr", 32'(mem_if.mem_adr), 0);

        repeat (2) @(negedge clk);
        chk("idle_en", 32'(mem_if.mem_en), 0);

        acc(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1);
        chk("wr_lat", lat, 2);
        chk("wr_err", 32'(err), 0);
        chk("wr_en_cyc", en_cyc, 1);
        chk("wr_en_n", en_n, 1);
        chk("wr_mem_we", 32'(iss_we), 1);
        chk("wr_mem_adr", 32'(iss_adr), 4);
        chk("wr_mem_wd", iss_wd, 32'hDEAD_BEEF);

        @(negedge clk);
        acc(1'b0, 32'h0000_0010, 32'h0, 1);
        chk("rd_lat", lat, 4);
        chk("rd_err", 32'(err), 0);
        chk("rd_en_cyc", en_cyc, 1);
        chk("rd_en_n", en_n, 1);
        chk("rd_mem_we", 32'(iss_we), 0);
        chk("rd_data", cpu_if.cpu_rdata, 32'hDEAD_BEEF);

        @(negedge clk);
        acc(1'b0, 32'h0000_0013, 32'h0, 1);
        chk("mis_rd_lat", lat, 2);
        chk("mis_rd_err", 32'(err), 1);
        chk("mis_rd_en_n", en_n, 0);
        chk("mis_rd_data", cpu_if.cpu_rdata, 32'hDEAD_BEEF);
        chk("mis_rd_errbad", err_bad, 0);
        @(negedge clk);
        chk("mis_err_clear", 32'(cpu_if.cpu_err), 0);

        acc(1'b1, 32'h0000_0012, 32'h5555_AAAA, 1);
        chk("mis_wr_lat", lat, 2);
        chk("mis_wr_err", 32'(err), 1);
        chk("mis_wr_en_n", en_n, 0);

        @(negedge clk);
        acc(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 0);
        chk("b2b_wr_lat", lat, 2);
        chk("b2b_wr_err", 32'(err), 0);
        acc(1'b0, 32'h0000_0020, 32'h0, 2);
        chk("b2b_rd_en_cyc", en_cyc, 2);
        chk("b2b_rd_lat", lat, 5);
        chk("b2b_rd_data", cpu_if.cpu_rdata, 32'hCAFE_F00D);

        @(negedge clk);
        acc(1'b1, 32'h0000_1000, 32'h1111_1111, 1);
        chk("wrap_wr_lat", lat, 2);
        chk("wrap_wr_adr", 32'(iss_adr), 0);
        @(negedge clk);
        acc(1'b0, 32'h0000_0000, 32'h0, 1);
        chk("wrap_rd_lat", lat, 4);
        chk("wrap_rd_data", cpu_if.cpu_rdata, 32'h1111_1111);

        @(negedge clk);
        cpu_if.cpu_req   = 1'b1;
        cpu_if.cpu_we    = 1'b0;
        cpu_if.cpu_adr   = 32'h0000_0010;
        @(negedge clk);
        cpu_if.cpu_req = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("mid_rst_ready", 32'(cpu_if.cpu_ready), 0);
        chk("mid_rst_err", 32'(cpu_if.cpu_err), 0);
        chk("mid_rst_rdata", cpu_if.cpu_rdata, 0);
        chk("mid_rst_en", 32'(mem_if.mem_en), 0);
        chk("mid_rst_we", 32'(mem_if.mem_we), 0);
        chk("mid_rst_adr", 32'(mem_if.mem_adr), 0);
        chk("mid_rst_wd", mem_if.mem_wdata, 0);
        rdy_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (cpu_if.cpu_ready) rdy_seen++;
        end
        chk("mid_rst_no_ready", rdy_seen, 0);

        acc(1'b0, 32'h0000_0010, 32'h0, 1);
        chk("post_rst_lat", lat, 4);
        chk("post_rst_data", cpu_if.cpu_rdata, 32'hDEAD_BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
